// File: rtl/prio_grant_sched.sv
// Priority grant scheduler: shares one resource among N requesters.
// The lowest priority value wins. Ties go to the first eligible index found
// scanning upward from a rotating pointer. A grant is held until done, until
// the holder abandons its request, or until the hold limit expires. Every
// grant is followed by one dead GAP cycle.
// timeout_o is registered at the edge that ends a timed-out grant, so it is
// high during the GAP cycle that follows the last grant cycle.
module prio_grant_sched #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int MAX_HOLD  = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N-1:0]             req_i,
  input  logic [N*PRIO_BITS-1:0]   prio_i,
  input  logic                     mask_we_i,
  input  logic [N-1:0]             mask_i,
  input  logic                     done_i,
  output logic [N-1:0]             gnt_o,
  output logic                     gnt_valid_o,
  output logic [$clog2(N)-1:0]     gnt_sel_o,
  output logic [PRIO_BITS-1:0]     gnt_prio_o,
  output logic                     timeout_o
);

  localparam int SEL_W = $clog2(N);
  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? CNT_W'(0) : CNT_W'(MAX_HOLD - 1);
  localparam logic TO_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state_r;
  logic [N-1:0]           mask_r;
  logic [SEL_W-1:0]       rr_ptr_r;
  logic [CNT_W-1:0]       hold_cnt_r;

  logic [N-1:0]           elig;
  logic                   any_elig;
  logic [SEL_W-1:0]       win_idx;
  logic [PRIO_BITS-1:0]   win_prio;
  logic [SEL_W-1:0]       scan_idx;
  logic [PRIO_BITS-1:0]   scan_prio;
  logic                   release_now;
  logic                   expire_now;

  // Priority field of source i from the packed priority bus.
  function automatic logic [PRIO_BITS-1:0] prio_of(input logic [N*PRIO_BITS-1:0] v,
                                                   input logic [SEL_W-1:0] i);
    return v[i*PRIO_BITS +: PRIO_BITS];
  endfunction

  // One-hot decode of a source index.
  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  assign elig        = req_i & mask_r;
  assign release_now = done_i | ~req_i[gnt_sel_o];
  assign expire_now  = TO_EN & (hold_cnt_r == HOLD_LAST);

  // Winner search: rotate from rr_ptr, keep the first strictly-better priority.
  always_comb begin
    any_elig  = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    scan_idx  = '0;
    scan_prio = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx  = rr_ptr_r + SEL_W'(k);
      scan_prio = prio_of(prio_i, scan_idx);
      if (elig[scan_idx] && (!any_elig || (scan_prio < win_prio))) begin
        any_elig = 1'b1;
        win_idx  = scan_idx;
        win_prio = scan_prio;
      end else begin
        any_elig = any_elig;
      end
    end
  end

  // Enable mask register; writable in any state, consulted only at arbitration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_r <= '1;
    end else if (mask_we_i) begin
      mask_r <= mask_i;
    end else begin
      mask_r <= mask_r;
    end
  end

  // Scheduler FSM with registered grant outputs, hold counter and rr pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      hold_cnt_r  <= '0;
      gnt_o       <= '0;
      gnt_valid_o <= 1'b0;
      gnt_sel_o   <= '0;
      gnt_prio_o  <= '0;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_elig) begin
            gnt_o       <= onehot(win_idx);
            gnt_valid_o <= 1'b1;
            gnt_sel_o   <= win_idx;
            gnt_prio_o  <= win_prio;
            hold_cnt_r  <= '0;
            state_r     <= GRANT;
          end else begin
            state_r     <= IDLE;
          end
        end
        GRANT: begin
          if (release_now || expire_now) begin
            // Normal release takes precedence over a simultaneous timeout.
            timeout_o   <= ~release_now & expire_now;
            rr_ptr_r    <= gnt_sel_o + SEL_W'(1);
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            gnt_sel_o   <= '0;
            gnt_prio_o  <= '0;
            state_r     <= GAP;
          end else if (hold_cnt_r != CNT_MAX) begin
            hold_cnt_r  <= hold_cnt_r + CNT_W'(1);
          end else begin
            hold_cnt_r  <= hold_cnt_r;
          end
        end
        GAP: begin
          state_r <= IDLE;
        end
        default: begin
          gnt_o       <= '0;
          gnt_valid_o <= 1'b0;
          gnt_sel_o   <= '0;
          gnt_prio_o  <= '0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_grant_sched.sv
// Directed testbench for prio_grant_sched (N=8, PRIO_BITS=3, MAX_HOLD=4).
module tb_prio_grant_sched;

  localparam int N  = 8;
  localparam int PB = 3;
  localparam int MH = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*PB-1:0] prio;
  logic            mask_we;
  logic [N-1:0]    mask;
  logic            done;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [2:0]      gnt_sel;
  logic [PB-1:0]   gnt_prio;
  logic            timeout;

  int n_checks = 0;
  int n_errors = 0;

  prio_grant_sched #(.N(N), .PRIO_BITS(PB), .MAX_HOLD(MH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .prio_i      (prio),
    .mask_we_i   (mask_we),
    .mask_i      (mask),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_sel_o   (gnt_sel),
    .gnt_prio_o  (gnt_prio),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int i, input logic [PB-1:0] p);
    prio[i*PB +: PB] = p;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    prio    = {N{3'd7}};
    mask_we = 1'b0;
    mask    = '0;
    done    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    prio    = {N{3'd7}};
    mask_we = 1'b0;
    mask    = '0;
    done    = 1'b0;
    #2;
    // 1: reset values, then idle with no requests
    check("rst_gnt",     32'(gnt), 32'h0);
    check("rst_valid",   32'(gnt_valid), 32'h0);
    check("rst_sel",     32'(gnt_sel), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_gnt", 32'(gnt), 32'h0);
    end

    // 2: priority wins over index; next grant after GAP and IDLE
    set_prio(1, 3'd5);
    set_prio(5, 3'd2);
    req = 8'h22;
    tick();
    check("t2_gnt",   32'(gnt), 32'h20);
    check("t2_sel",   32'(gnt_sel), 32'd5);
    check("t2_prio",  32'(gnt_prio), 32'd2);
    check("t2_valid", 32'(gnt_valid), 32'h1);
    done = 1'b1;
    req  = 8'h02;
    tick();
    done = 1'b0;
    check("t2_gap_gnt",   32'(gnt), 32'h0);
    check("t2_gap_valid", 32'(gnt_valid), 32'h0);
    check("t2_gap_sel",   32'(gnt_sel), 32'h0);
    tick();
    check("t2_idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("t2_gnt2",  32'(gnt), 32'h02);
    check("t2_sel2",  32'(gnt_sel), 32'd1);
    check("t2_prio2", 32'(gnt_prio), 32'd5);

    // 3: round-robin among equal priorities 0, 3, 6
    do_reset();
    set_prio(0, 3'd1);
    set_prio(3, 3'd1);
    set_prio(6, 3'd1);
    req = 8'h49;
    tick();
    begin
      int order [4] = '{0, 3, 6, 0};
      for (int g = 0; g < 4; g++) begin
        check("t3_order", 32'(gnt), 32'(1 << order[g]));
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t3_gap", 32'(gnt), 32'h0);
        tick();
        tick();
      end
    end

    // 4: timeout after exactly MAX_HOLD cycles, then done in the last cycle
    do_reset();
    set_prio(4, 3'd0);
    req = 8'h10;
    for (int c = 0; c < MH; c++) begin
      tick();
      check("t4_hold_gnt", 32'(gnt), 32'h10);
      check("t4_hold_to",  32'(timeout), 32'h0);
    end
    tick();
    check("t4_exp_gnt", 32'(gnt), 32'h0);
    check("t4_exp_to",  32'(timeout), 32'h1);
    tick();
    check("t4_to_pulse_end", 32'(timeout), 32'h0);
    tick();
    check("t4_regrant", 32'(gnt), 32'h10);
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    check("t4_done_gnt", 32'(gnt), 32'h0);
    check("t4_done_to",  32'(timeout), 32'h0);
    tick();

    // 5: mask write never revokes a grant; masked source stays excluded
    set_prio(2, 3'd3);
    req = 8'h04;
    tick();
    check("t5_gnt2", 32'(gnt), 32'h04);
    mask_we = 1'b1;
    mask    = 8'hFB;
    set_prio(1, 3'd0);
    req     = 8'h06;
    tick();
    mask_we = 1'b0;
    check("t5_keep_a", 32'(gnt), 32'h04);
    tick();
    check("t5_keep_b", 32'(gnt), 32'h04);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    check("t5_gnt1", 32'(gnt), 32'h02);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    check("t5_gnt1_again", 32'(gnt), 32'h02);
    req = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_masked_idle", 32'(gnt), 32'h0);
    end
    mask_we = 1'b1;
    mask    = 8'hFF;
    tick();
    mask_we = 1'b0;
    req     = '0;
    tick();
    tick();
    tick();

    // 6: abandon mid-grant advances the pointer past the holder
    do_reset();
    set_prio(1, 3'd0);
    set_prio(2, 3'd0);
    req = 8'h06;
    tick();
    check("t6_gnt1", 32'(gnt), 32'h02);
    tick();
    req = 8'h04;
    tick();
    check("t6_abandon_gap", 32'(gnt), 32'h0);
    req = 8'h06;
    tick();
    tick();
    check("t6_rr_gnt", 32'(gnt), 32'h04);
    check("t6_rr_sel", 32'(gnt_sel), 32'd2);

    // 1b: asynchronous reset drops an active grant before any clock edge
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt",   32'(gnt), 32'h0);
    check("async_rst_valid", 32'(gnt_valid), 32'h0);
    #1;
    rst_n = 1'b1;
    req   = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
